// File: rtl/uart_hex_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_hex_tx_pkg
//   Shared definitions for the calculator result UART link:
//     - ASCII constants used to build the transmitted line
//     - frame geometry of one 8N1 character
//     - sequencer state encoding
//     - nibble -> uppercase ASCII hex conversion
// -----------------------------------------------------------------------------
package uart_hex_tx_pkg;

    // ASCII characters that appear on the line
    localparam logic [7:0] ASCII_EQ   = 8'h3D;  // '=' : no overflow
    localparam logic [7:0] ASCII_V    = 8'h56;  // 'V' : overflow / carry
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;  // '0'
    localparam logic [7:0] ASCII_A    = 8'h41;  // 'A'

    // One character on the wire: start + 8 data + stop
    localparam int FRAME_BITS = 10;

    // LOAD is the zero-length phase in which the next character is handed
    // to the byte transmitter; it is never held in the state register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        logic [7:0] ch;
        if (n < 4'd10) begin
            ch = ASCII_ZERO + {4'd0, n};
        end else begin
            ch = ASCII_A + {4'd0, n - 4'd10};
        end
        return ch;
    endfunction

endpackage

// File: rtl/uart_hex_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//   Sends one 8N1 character: start bit (0), d0..d7 LSB first, stop bit (1).
//   Every bit is held for exactly DIV clock cycles.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset (line forced idle-high)
//   load       in   start a new character with byte_data (wins over anything
//                   in flight, which lets the caller chain characters)
//   byte_data  in   character to send, sampled when load=1
//   tx         out  serial line, registered, idles high
//   ready      out  high during the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte
    import uart_hex_tx_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       ready
);

    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    logic [CNT_W-1:0]      baud_cnt;
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic                  active;
    logic                  bit_end;

    assign bit_end = active && (baud_cnt == CNT_LAST);
    assign ready   = bit_end && (bit_idx == BIT_LAST);

    // The line is the LSB of the shifter; ones are shifted in behind the
    // frame so the register naturally settles back to idle-high.
    assign tx = shreg[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            active   <= 1'b0;
        end else if (load) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= {1'b1, byte_data, 1'b0};
            active   <= 1'b1;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
                if (bit_idx == BIT_LAST) begin
                    bit_idx <= '0;
                    active  <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_hex_tx.sv
// -----------------------------------------------------------------------------
// uart_hex_tx
//   Outbound PC link for calculator results. On an accepted start the result
//   word and overflow flag are latched and one ASCII line is sent over 8N1:
//     flag char ('=' or 'V'), NIBBLES uppercase hex digits MS nibble first,
//     CR, LF.
//   Characters are chained with no idle gap; a new line may be requested in
//   the cycle that done is high, giving back-to-back lines.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-high reset; aborts any line in flight
//   start  in   1-cycle request, accepted only while busy=0
//   data   in   result word (4*NIBBLES bits), sampled on the accepted start
//   cout   in   overflow/carry flag, sampled with data
//   tx     out  UART line, idles high
//   busy   out  high while a line is in flight (low in the done cycle)
//   done   out  1-cycle pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_hex_tx
    import uart_hex_tx_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 9600,
    parameter int NIBBLES = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] data,
    input  logic                 cout,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int DATA_W = 4 * NIBBLES;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int NCHARS = NIBBLES + 3;
    localparam int CHAR_W = $clog2(NCHARS);

    localparam logic [CHAR_W-1:0] LAST_IDX = CHAR_W'(NCHARS - 1);

    state_t              state;
    state_t              state_nxt;
    state_t              phase;
    logic [CHAR_W-1:0]   char_idx;
    logic [DATA_W-1:0]   data_q;
    logic                cout_q;
    logic                last_char;
    logic                accept;
    logic                advance;
    logic                byte_load;
    logic                byte_ready;
    logic [7:0]          byte_sel;

    // Character at position idx of the line built from (word, flag):
    //   0 -> flag, 1..NIBBLES -> hex digits MS first, then CR, then LF.
    function automatic logic [7:0] char_at(input logic [CHAR_W-1:0] idx,
                                           input logic [DATA_W-1:0] word,
                                           input logic              flag);
        logic [7:0] ch;
        ch = ASCII_LF;
        if (idx == '0) begin
            ch = flag ? ASCII_V : ASCII_EQ;
        end else if (idx == CHAR_W'(NIBBLES + 1)) begin
            ch = ASCII_CR;
        end else if (idx == CHAR_W'(NIBBLES + 2)) begin
            ch = ASCII_LF;
        end else begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == CHAR_W'(i + 1)) begin
                    ch = nibble_to_ascii(word[DATA_W-4-4*i +: 4]);
                end
            end
        end
        return ch;
    endfunction

    assign last_char = (char_idx == LAST_IDX);

    // Sequencer: next state, handshake outputs and the character to load.
    always_comb begin
        state_nxt = state;
        phase     = state;
        accept    = 1'b0;
        advance   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                busy = 1'b1;
                if (byte_ready) begin
                    if (last_char) begin
                        // Final stop bit ends this cycle: the line is over,
                        // so a new request can be taken on this very edge.
                        done = 1'b1;
                        busy = 1'b0;
                        if (start) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (accept || advance) begin
            phase = ST_LOAD;
        end

        // The first character comes straight from the inputs so the start
        // bit appears the cycle after accept; later ones use the latch.
        if (accept) begin
            byte_sel = char_at('0, data, cout);
        end else begin
            byte_sel = char_at(char_idx + CHAR_W'(1), data_q, cout_q);
        end
    end

    assign byte_load = (phase == ST_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            char_idx <= '0;
            data_q   <= '0;
            cout_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_q   <= data;
                cout_q   <= cout;
                char_idx <= '0;
            end else if (advance) begin
                char_idx <= char_idx + CHAR_W'(1);
            end else if (done) begin
                char_idx <= '0;
            end
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .load      (byte_load),
        .byte_data (byte_sel),
        .tx        (tx),
        .ready     (byte_ready)
    );

endmodule

// File: tb/tb_uart_hex_tx.sv
module tb_uart_hex_tx;

    localparam int CLK_HZ   = 16;
    localparam int BAUD     = 1;
    localparam int NIBBLES  = 10;
    localparam int DIV      = CLK_HZ / BAUD;
    localparam int LINE_CYC = 13 * 10 * DIV;
    localparam int HIST_N   = 16384;

    typedef byte unsigned bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [39:0] data;
    logic        cout;
    logic        tx;
    logic        busy;
    logic        done;

    uart_hex_tx #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .NIBBLES (NIBBLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .cout  (cout),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   m_q[$];            // expected TX value for every remaining line cycle
    bq_t  rx_q;              // characters decoded from the DUT line
    logic tx_hist[0:HIST_N-1];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic string show(input bq_t q);
        string s;
        s = "";
        foreach (q[i]) begin
            if (q[i] >= 8'h20 && q[i] < 8'h7F) s = {s, $sformatf("%c", q[i])};
            else s = {s, $sformatf("<%02h>", q[i])};
        end
        return s;
    endfunction

    task automatic chk_q(input string name, input bq_t act, input bq_t exp);
        bit ok;
        checks++;
        ok = (act.size() == exp.size());
        if (ok) foreach (exp[i]) if (act[i] !== exp[i]) ok = 0;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=\"%s\" required=\"%s\"", name, show(act), show(exp));
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // ---------------- behavioural model ----------------
    // The line as text: flag, 10 hex digits looked up from a digit table, CR, LF.
    function automatic bq_t line_bytes(input logic [39:0] d, input logic c);
        bq_t   q;
        string hexdig;
        int    n;
        hexdig = "0123456789ABCDEF";
        q.push_back(c ? 8'h56 : 8'h3D);
        for (int i = NIBBLES - 1; i >= 0; i--) begin
            n = int'((d >> (4 * i)) & 40'hF);
            q.push_back(hexdig[n]);
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    // Expand the text into the per-cycle waveform of an 8N1 line.
    task automatic push_line(input logic [39:0] d, input logic c);
        bq_t          l;
        byte unsigned ch;
        bit           v;
        l = line_bytes(d, c);
        foreach (l[k]) begin
            ch = l[k];
            for (int b = 0; b < 10; b++) begin
                if (b == 0) v = 1'b0;
                else if (b == 9) v = 1'b1;
                else v = ch[b-1];
                repeat (DIV) m_q.push_back(v);
            end
        end
    endtask

    // A line is in flight while cycles remain; the last remaining cycle is the
    // DONE cycle, in which a new request is already allowed.
    always @(posedge clk) begin : model
        bit acc;
        cyc <= cyc + 1;
        if (rst) begin
            m_q.delete();
        end else begin
            acc = (start === 1'b1) && (m_q.size() <= 1);
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (acc) push_line(data, cout);
        end
    end

    // Single per-cycle compare of {tx, busy, done} against the model.
    always @(negedge clk) begin : compare
        logic [2:0] e;
        if (rst) e = 3'b100;
        else e = {(m_q.size() > 0) ? logic'(m_q[0]) : 1'b1,
                  logic'(m_q.size() > 1),
                  logic'(m_q.size() == 1)};
        chk("cycle_tx_busy_done", {61'd0, tx, busy, done}, {61'd0, e});
        if (cyc < HIST_N) tx_hist[cyc] = tx;
    end

    // UART receiver on the DUT line: samples each bit mid-way.
    int       dec_cnt = 0;
    bit       dec_on  = 0;
    logic [9:0] dec_sh;
    always @(negedge clk) begin : decoder
        if (rst) begin
            dec_on = 0;
        end else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on  = 1;
                dec_cnt = 1;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt >= DIV / 2 && ((dec_cnt - DIV / 2) % DIV) == 0 && (dec_cnt - DIV / 2) / DIV < 10)
                dec_sh[(dec_cnt - DIV / 2) / DIV] = tx;
            if (dec_cnt == 9 * DIV + DIV / 2) rx_q.push_back(dec_sh[8:1]);
            if (dec_cnt == 10 * DIV) dec_on = 0;
        end
    end

    function automatic int run_len(input int idx, input logic v);
        int n;
        n = 0;
        while (idx + n < HIST_N && tx_hist[idx + n] === v) n++;
        return n;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, output int done_edge);
        bit seen;
        seen      = 0;
        done_edge = -1;
        for (int i = 0; i < LINE_CYC + 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen      = 1;
                done_edge = cyc + 1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done_timeout actual=no_done required=done_within_%0d_cycles", name, LINE_CYC + 200);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a1, a2, a4, a5, a6;
        int d1, d2, d4, d5, d6;
        rst = 1'b1; start = 1'b0; data = '0; cout = 1'b0;
        step(3);
        @(negedge clk);
        chk("reset_state_tx_busy_done", {61'd0, tx, busy, done}, 64'h4);
        step(1);
        rst = 1'b0;
        step(2);

        // Model pinned against a hand-written line
        chk_q("model_line_t1", line_bytes(40'h0123456789, 1'b0), str2q("=0123456789\015\012"));

        // Line 1, with an ignored START and DATA changes while busy
        rx_q.delete();
        data = 40'h0123456789; cout = 1'b0; start = 1'b1;
        step(1);
        a1 = cyc; start = 1'b0;
        step(99);
        data = 40'hFFFFFFFFFF; cout = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0; data = 40'h5555555555;
        @(negedge clk);
        chk("t3_busy_held", {63'd0, busy}, 64'd1);
        wait_done("t1", d1);
        chk("t1_done_latency", 64'(d1 - a1), 64'd2080);
        chk_q("t1_line", rx_q, str2q("=0123456789\015\012"));
        chk("t1_start_bit_len", 64'(run_len(a1, 1'b0)), 64'd16);
        chk("t1_stop_bit_len", 64'(run_len(a1 + 144, 1'b1)), 64'd16);

        // Line 2: letters, overflow flag
        step(3);
        rx_q.delete();
        data = 40'hABCDEF0000; cout = 1'b1; start = 1'b1;
        step(1);
        a2 = cyc; start = 1'b0; data = 40'h0;
        wait_done("t2", d2);
        chk("t2_done_latency", 64'(d2 - a2), 64'd2080);
        chk_q("t2_line", rx_q, str2q("VABCDEF0000\015\012"));

        // START in the DONE cycle: back-to-back line
        rx_q.delete();
        data = 40'h1F2E3D4C5B; cout = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a5 = cyc; start = 1'b0;
        chk("t5_accept_on_done_edge", 64'(a5), 64'(d2));
        @(negedge clk);
        chk("t5_tx_start_next_cycle", {63'd0, tx}, 64'd0);
        chk("t5_stop_then_start_no_gap", {63'd0, tx_hist[a5 - 1]}, 64'd1);
        wait_done("t5", d5);
        chk("t5_done_latency", 64'(d5 - a5), 64'd2080);
        chk_q("t5_line", rx_q, str2q("=1F2E3D4C5B\015\012"));

        // Reset mid-character, then a fresh line
        step(3);
        rx_q.delete();
        data = 40'h0F0F0F0F0F; cout = 1'b0; start = 1'b1;
        step(1);
        a4 = cyc; start = 1'b0;
        step(499);
        chk("t4_busy_before_reset", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t4_async_reset_tx_busy_done", {61'd0, tx, busy, done}, 64'h4);
        step(2);
        rst = 1'b0;
        step(2);
        d4 = a4;
        rx_q.delete();
        data = 40'h9876543210; cout = 1'b1; start = 1'b1;
        step(1);
        a6 = cyc; start = 1'b0;
        wait_done("t4_after_reset", d6);
        chk("t4_done_latency", 64'(d6 - a6), 64'd2080);
        chk_q("t4_fresh_line", rx_q, str2q("V9876543210\015\012"));
        chk("t4_line_restarted_later", 64'(a6 > d4), 64'd1);

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
